// File: rtl/burst_write_sequencer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst sequencer and the master port.
// Suffixes are from the sequencer's point of view: _o driven by the master, _i by the slave.
interface burst_write_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   m_awaddr_o;
  logic [7:0]              m_awlen_o;
  logic [2:0]              m_awsize_o;
  logic [1:0]              m_awburst_o;
  logic                    m_awvalid_o;
  logic                    m_awready_i;
  logic [DATA_WIDTH-1:0]   m_wdata_o;
  logic [DATA_WIDTH/8-1:0] m_wstrb_o;
  logic                    m_wlast_o;
  logic                    m_wvalid_o;
  logic                    m_wready_i;
  logic [1:0]              m_bresp_i;
  logic                    m_bvalid_i;
  logic                    m_bready_o;

  modport master (
    output m_awaddr_o, m_awlen_o, m_awsize_o, m_awburst_o, m_awvalid_o,
    output m_wdata_o, m_wstrb_o, m_wlast_o, m_wvalid_o, m_bready_o,
    input  m_awready_i, m_wready_i, m_bresp_i, m_bvalid_i
  );

  modport slave (
    input  m_awaddr_o, m_awlen_o, m_awsize_o, m_awburst_o, m_awvalid_o,
    input  m_wdata_o, m_wstrb_o, m_wlast_o, m_wvalid_o, m_bready_o,
    output m_awready_i, m_wready_i, m_bresp_i, m_bvalid_i
  );
endinterface

// File: rtl/burst_write_sequencer.sv
// Issues ping-pong INCR write bursts of an incrementing counter; AW, then W beats, then B, strictly in order.
// Optional ERR_HALT_EN: an error response ends the session until cfg_enable_i is seen low then high again.
module burst_write_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  cfg_enable_i,
  input  logic [ADDR_WIDTH-1:0] cfg_addr0_i,
  input  logic [ADDR_WIDTH-1:0] cfg_addr1_i,
  input  logic [7:0]            cfg_length_i,
  input  logic [DATA_WIDTH-1:0] cfg_incr_i,
  burst_write_sequencer_if.master m,
  output logic                  busy_o,
  output logic                  buf_sel_o,
  output logic [CNT_WIDTH-1:0]  burst_cnt_o,
  output logic                  err_o
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]            beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;
  logic                  buf_sel_q, buf_sel_d;
  logic                  err_q, err_d;
  logic [7:0]            len_q, len_d;
  logic [DATA_WIDTH-1:0] incr_q, incr_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [7:0]            awlen_q, awlen_d;

  logic cfg_ok, resp_err, last_beat, may_start, halt_now;

  assign cfg_ok    = cfg_enable_i && (cfg_length_i != 8'd0);
  assign resp_err  = (m.m_bresp_i != 2'b00);
  assign last_beat = (beat_q == len_q - 8'd1);

`ifdef ERR_HALT_EN
  // Set by an error response; only a low enable seen in IDLE re-arms session start.
  logic halt_q;
  always_ff @(posedge clk) begin
    if (!areset) begin
      halt_q <= 1'b0;
    end else if (state_q == RESP && m.m_bvalid_i && resp_err) begin
      halt_q <= 1'b1;
    end else if (state_q == IDLE && !cfg_enable_i) begin
      halt_q <= 1'b0;
    end
  end
  assign may_start = cfg_ok && !halt_q;
  assign halt_now  = resp_err;
`else
  assign may_start = cfg_ok;
  assign halt_now  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    burst_cnt_d = burst_cnt_q;
    buf_sel_d   = buf_sel_q;
    err_d       = err_q;
    len_d       = len_q;
    incr_d      = incr_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    unique case (state_q)
      IDLE: begin
        if (may_start) begin
          cnt_d       = '0;
          beat_d      = 8'd0;
          burst_cnt_d = '0;
          buf_sel_d   = 1'b0;
          err_d       = 1'b0;
          len_d       = cfg_length_i;
          incr_d      = cfg_incr_i;
          awaddr_d    = cfg_addr0_i;
          awlen_d     = cfg_length_i - 8'd1;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        if (m.m_awready_i) state_d = DATA;
      end
      DATA: begin
        if (m.m_wready_i) begin
          cnt_d  = cnt_q + incr_q;
          beat_d = beat_q + 8'd1;
          if (last_beat) begin
            beat_d  = 8'd0;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (m.m_bvalid_i) begin
          burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
          buf_sel_d   = ~buf_sel_q;
          err_d       = err_q | resp_err;
          // Config is resampled only here, at the burst boundary; address follows the toggled buffer.
          if (cfg_ok && !halt_now) begin
            len_d    = cfg_length_i;
            incr_d   = cfg_incr_i;
            awaddr_d = buf_sel_q ? cfg_addr0_i : cfg_addr1_i;
            awlen_d  = cfg_length_i - 8'd1;
            state_d  = ADDR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      beat_q      <= 8'd0;
      burst_cnt_q <= '0;
      buf_sel_q   <= 1'b0;
      err_q       <= 1'b0;
      len_q       <= 8'd0;
      incr_q      <= '0;
      awaddr_q    <= '0;
      awlen_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      burst_cnt_q <= burst_cnt_d;
      buf_sel_q   <= buf_sel_d;
      err_q       <= err_d;
      len_q       <= len_d;
      incr_q      <= incr_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
    end
  end

  assign m.m_awaddr_o  = awaddr_q;
  assign m.m_awlen_o   = awlen_q;
  assign m.m_awsize_o  = 3'($clog2(DATA_WIDTH / 8));
  assign m.m_awburst_o = 2'b01;
  assign m.m_awvalid_o = (state_q == ADDR);
  assign m.m_wdata_o   = cnt_q;
  assign m.m_wstrb_o   = '1;
  assign m.m_wlast_o   = (state_q == DATA) && last_beat;
  assign m.m_wvalid_o  = (state_q == DATA);
  assign m.m_bready_o  = (state_q == RESP);

  assign busy_o      = (state_q != IDLE);
  assign buf_sel_o   = buf_sel_q;
  assign burst_cnt_o = burst_cnt_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_burst_write_sequencer.sv
// Directed bench: a slave model answers each burst, captures AW/W traffic, and each test task checks it.
module tb_burst_write_sequencer;
  logic        clk = 1'b0;
  logic        areset = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [31:0] cfg_addr0 = 32'h0, cfg_addr1 = 32'h0, cfg_incr = 32'h0;
  logic [7:0]  cfg_length = 8'h0;
  logic        busy, buf_sel, err;
  logic [15:0] burst_cnt;
  int          comps = 0;
  int          fails = 0;

  // Capture of the most recent burst
  logic [31:0] cap_addr;
  logic [7:0]  cap_len;
  logic [31:0] cap_d [16];
  int          cap_n, cap_last, cap_unst;
  bit          cap_tmo;

  burst_write_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  burst_write_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .areset(areset),
    .cfg_enable_i(cfg_enable), .cfg_addr0_i(cfg_addr0), .cfg_addr1_i(cfg_addr1),
    .cfg_length_i(cfg_length), .cfg_incr_i(cfg_incr),
    .m(bus),
    .busy_o(busy), .buf_sel_o(buf_sel), .burst_cnt_o(burst_cnt), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset();
    areset = 1'b0;
    cfg_enable = 1'b0;
    bus.m_awready_i = 1'b0; bus.m_wready_i = 1'b0; bus.m_bvalid_i = 1'b0; bus.m_bresp_i = 2'b00;
    repeat (3) @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_cfg(input logic [7:0] len, input logic [31:0] incr);
    cfg_addr0 = 32'h43C1_0000; cfg_addr1 = 32'h43C2_0000;
    cfg_length = len; cfg_incr = incr;
  endtask

  // Plays the slave for one full burst; entered and left at a negedge.
  task automatic do_burst(input int aw_dly, input bit wstall, input logic [1:0] resp, input int drop_beat);
    int t, cyc;
    bit stalled, done, rdy;
    logic [31:0] pd;
    logic pl;
    cap_tmo = 0; cap_unst = 0; cap_n = 0; cap_last = -1;
    t = 0;
    while (!bus.m_awvalid_o && t < 200) begin
      if (bus.m_wvalid_o) cap_unst++;
      @(negedge clk); t++;
    end
    if (t >= 200) begin cap_tmo = 1; return; end
    cap_addr = bus.m_awaddr_o; cap_len = bus.m_awlen_o;
    for (int i = 0; i < aw_dly; i++) begin
      @(negedge clk);
      if (!bus.m_awvalid_o || bus.m_awaddr_o !== cap_addr || bus.m_awlen_o !== cap_len) cap_unst++;
      if (bus.m_wvalid_o) cap_unst++;
    end
    bus.m_awready_i = 1'b1;
    @(negedge clk);
    bus.m_awready_i = 1'b0;
    t = 0; cyc = 0; stalled = 0; done = 0; pd = 32'h0; pl = 1'b0;
    while (!done && t < 300) begin
      if (bus.m_awvalid_o) cap_unst++;
      if (bus.m_wvalid_o) begin
        if (stalled && (bus.m_wdata_o !== pd || bus.m_wlast_o !== pl)) cap_unst++;
        rdy = wstall ? (cyc % 3 == 2) : 1'b1;
        cyc++;
        bus.m_wready_i = rdy;
        if (rdy) begin
          if (cap_n < 16) cap_d[cap_n] = bus.m_wdata_o;
          if (bus.m_wlast_o) begin cap_last = cap_n; done = 1; end
          if (cap_n == drop_beat) cfg_enable = 1'b0;
          cap_n++;
          stalled = 0;
        end else begin
          stalled = 1; pd = bus.m_wdata_o; pl = bus.m_wlast_o;
        end
      end
      @(negedge clk);
      bus.m_wready_i = 1'b0;
      t++;
    end
    if (!done) begin cap_tmo = 1; return; end
    t = 0;
    while (!bus.m_bready_o && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin cap_tmo = 1; return; end
    bus.m_bvalid_i = 1'b1; bus.m_bresp_i = resp;
    @(negedge clk);
    bus.m_bvalid_i = 1'b0; bus.m_bresp_i = 2'b00;
  endtask

  task automatic test_reset();
    areset = 1'b0;
    repeat (2) @(negedge clk);
    comps++; if (bus.m_awvalid_o !== 1'b0) begin fails++; $display("FAIL reset_awvalid got=%0h exp=0", bus.m_awvalid_o); end
    comps++; if (bus.m_wvalid_o !== 1'b0) begin fails++; $display("FAIL reset_wvalid got=%0h exp=0", bus.m_wvalid_o); end
    comps++; if (bus.m_wlast_o !== 1'b0) begin fails++; $display("FAIL reset_wlast got=%0h exp=0", bus.m_wlast_o); end
    comps++; if (bus.m_bready_o !== 1'b0) begin fails++; $display("FAIL reset_bready got=%0h exp=0", bus.m_bready_o); end
    comps++; if (bus.m_awaddr_o !== 32'h0) begin fails++; $display("FAIL reset_awaddr got=%0h exp=0", bus.m_awaddr_o); end
    comps++; if (bus.m_wdata_o !== 32'h0) begin fails++; $display("FAIL reset_wdata got=%0h exp=0", bus.m_wdata_o); end
    comps++; if (busy !== 1'b0 || buf_sel !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset_status got=%0b%0b%0b exp=000", busy, buf_sel, err); end
    comps++; if (burst_cnt !== 16'h0) begin fails++; $display("FAIL reset_burst_cnt got=%0h exp=0", burst_cnt); end
    comps++; if (bus.m_awsize_o !== 3'd2 || bus.m_awburst_o !== 2'b01 || bus.m_wstrb_o !== 4'hF) begin
      fails++; $display("FAIL reset_constants got=%0h/%0h/%0h exp=2/1/f", bus.m_awsize_o, bus.m_awburst_o, bus.m_wstrb_o); end
    areset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] exp_a;
    apply_reset();
    set_cfg(8'd4, 32'd4);
    cfg_enable = 1'b1;
    @(negedge clk);
    comps++; if (bus.m_awvalid_o !== 1'b1) begin fails++; $display("FAIL basic_awvalid_latency got=%0h exp=1", bus.m_awvalid_o); end
    for (int b = 0; b < 3; b++) begin
      if (b == 2) cfg_enable = 1'b0;
      do_burst(0, 0, 2'b00, -1);
      exp_a = (b == 1) ? 32'h43C2_0000 : 32'h43C1_0000;
      comps++; if (cap_tmo || cap_unst != 0) begin fails++; $display("FAIL basic_proto b%0d got tmo=%0d unstable=%0d exp=0/0", b, cap_tmo, cap_unst); end
      comps++; if (cap_addr !== exp_a || cap_len !== 8'd3) begin fails++; $display("FAIL basic_aw b%0d got=%0h/%0d exp=%0h/3", b, cap_addr, cap_len, exp_a); end
      comps++; if (cap_n != 4 || cap_last != 3) begin fails++; $display("FAIL basic_beats b%0d got n=%0d last=%0d exp=4/3", b, cap_n, cap_last); end
      for (int i = 0; i < 4; i++) begin
        comps++; if (cap_d[i] !== 32'(b * 16 + i * 4)) begin fails++; $display("FAIL basic_data b%0d[%0d] got=%0h exp=%0h", b, i, cap_d[i], b * 16 + i * 4); end
      end
      comps++; if (burst_cnt !== 16'(b + 1)) begin fails++; $display("FAIL basic_burst_cnt b%0d got=%0d exp=%0d", b, burst_cnt, b + 1); end
    end
    comps++; if (busy !== 1'b0 || buf_sel !== 1'b1) begin fails++; $display("FAIL basic_end got busy=%0b buf_sel=%0b exp=0/1", busy, buf_sel); end
  endtask

  task automatic test_enable_drop();
    apply_reset();
    set_cfg(8'd4, 32'd4);
    cfg_enable = 1'b1;
    @(negedge clk);
    do_burst(0, 0, 2'b00, 1);
    comps++; if (cap_tmo || cap_n != 4 || cap_d[3] !== 32'd12) begin fails++; $display("FAIL drop_burst got tmo=%0d n=%0d d3=%0h exp=0/4/c", cap_tmo, cap_n, cap_d[3]); end
    comps++; if (busy !== 1'b0 || burst_cnt !== 16'd1) begin fails++; $display("FAIL drop_idle got busy=%0b cnt=%0d exp=0/1", busy, burst_cnt); end
    repeat (5) @(negedge clk);
    comps++; if (bus.m_awvalid_o !== 1'b0 || burst_cnt !== 16'd1) begin fails++; $display("FAIL drop_hold got awvalid=%0b cnt=%0d exp=0/1", bus.m_awvalid_o, burst_cnt); end
  endtask

  task automatic test_stall();
    apply_reset();
    set_cfg(8'd4, 32'd4);
    cfg_enable = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      if (b == 1) cfg_enable = 1'b0;
      do_burst(5, 1, 2'b00, -1);
      comps++; if (cap_tmo || cap_unst != 0) begin fails++; $display("FAIL stall_stability b%0d got tmo=%0d unstable=%0d exp=0/0", b, cap_tmo, cap_unst); end
      comps++; if (cap_addr !== (b == 1 ? 32'h43C2_0000 : 32'h43C1_0000) || cap_last != 3) begin
        fails++; $display("FAIL stall_aw b%0d got=%0h last=%0d exp=b%0d/3", b, cap_addr, cap_last, b); end
      for (int i = 0; i < 4; i++) begin
        comps++; if (cap_d[i] !== 32'(b * 16 + i * 4)) begin fails++; $display("FAIL stall_data b%0d[%0d] got=%0h exp=%0h", b, i, cap_d[i], b * 16 + i * 4); end
      end
    end
    comps++; if (burst_cnt !== 16'd2) begin fails++; $display("FAIL stall_burst_cnt got=%0d exp=2", burst_cnt); end
  endtask

  task automatic test_len_zero();
    int aw_seen = 0, busy_seen = 0;
    apply_reset();
    set_cfg(8'd0, 32'd4);
    cfg_enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.m_awvalid_o) aw_seen++;
      if (busy) busy_seen++;
    end
    comps++; if (aw_seen != 0) begin fails++; $display("FAIL len0_awvalid got=%0d exp=0", aw_seen); end
    comps++; if (busy_seen != 0) begin fails++; $display("FAIL len0_busy got=%0d exp=0", busy_seen); end
    cfg_enable = 1'b0;
  endtask

  task automatic test_wrap();
    apply_reset();
    set_cfg(8'd3, 32'hFFFF_FFFF);
    cfg_enable = 1'b1;
    @(negedge clk);
    cfg_enable = 1'b0;
    do_burst(0, 0, 2'b00, -1);
    comps++; if (cap_tmo || cap_len !== 8'd2 || cap_n != 3 || cap_last != 2) begin
      fails++; $display("FAIL wrap_shape got tmo=%0d len=%0d n=%0d last=%0d exp=0/2/3/2", cap_tmo, cap_len, cap_n, cap_last); end
    comps++; if (cap_d[0] !== 32'h0) begin fails++; $display("FAIL wrap_d0 got=%0h exp=0", cap_d[0]); end
    comps++; if (cap_d[1] !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_d1 got=%0h exp=ffffffff", cap_d[1]); end
    comps++; if (cap_d[2] !== 32'hFFFF_FFFE) begin fails++; $display("FAIL wrap_d2 got=%0h exp=fffffffe", cap_d[2]); end
  endtask

  task automatic test_err();
    apply_reset();
    set_cfg(8'd4, 32'd4);
    cfg_enable = 1'b1;
    @(negedge clk);
    do_burst(0, 0, 2'b10, -1);
    comps++; if (cap_tmo || err !== 1'b1) begin fails++; $display("FAIL err_set got tmo=%0d err=%0b exp=0/1", cap_tmo, err); end
`ifdef ERR_HALT_EN
    comps++; if (busy !== 1'b0 || bus.m_awvalid_o !== 1'b0) begin fails++; $display("FAIL err_halt got busy=%0b awvalid=%0b exp=0/0", busy, bus.m_awvalid_o); end
    repeat (4) @(negedge clk);
    comps++; if (busy !== 1'b0) begin fails++; $display("FAIL err_halt_hold got busy=%0b exp=0", busy); end
    cfg_enable = 1'b0;
    @(negedge clk);
    cfg_enable = 1'b1;
    @(negedge clk);
    comps++; if (bus.m_awvalid_o !== 1'b1 || bus.m_awaddr_o !== 32'h43C1_0000 || err !== 1'b0) begin
      fails++; $display("FAIL err_restart got awvalid=%0b addr=%0h err=%0b exp=1/43c10000/0", bus.m_awvalid_o, bus.m_awaddr_o, err); end
    cfg_enable = 1'b0;
`else
    comps++; if (bus.m_awvalid_o !== 1'b1 || bus.m_awaddr_o !== 32'h43C2_0000) begin
      fails++; $display("FAIL err_continue got awvalid=%0b addr=%0h exp=1/43c20000", bus.m_awvalid_o, bus.m_awaddr_o); end
    cfg_enable = 1'b0;
    do_burst(0, 0, 2'b00, -1);
    comps++; if (cap_tmo || cap_d[0] !== 32'd16) begin fails++; $display("FAIL err_next_data got tmo=%0d d0=%0h exp=0/10", cap_tmo, cap_d[0]); end
    comps++; if (err !== 1'b1 || busy !== 1'b0 || burst_cnt !== 16'd2) begin
      fails++; $display("FAIL err_sticky got err=%0b busy=%0b cnt=%0d exp=1/0/2", err, busy, burst_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_cfg(8'd4, 32'd4);
    cfg_enable = 1'b1;
    @(negedge clk);
    bus.m_awready_i = 1'b1;
    @(negedge clk);
    bus.m_awready_i = 1'b0;
    bus.m_wready_i = 1'b1;
    @(negedge clk);
    bus.m_wready_i = 1'b0;
    comps++; if (bus.m_wvalid_o !== 1'b1 || bus.m_wdata_o !== 32'd4) begin fails++; $display("FAIL rstmid_pre got wvalid=%0b data=%0h exp=1/4", bus.m_wvalid_o, bus.m_wdata_o); end
    areset = 1'b0;
    @(negedge clk);
    comps++; if (bus.m_wvalid_o !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_abort got wvalid=%0b busy=%0b exp=0/0", bus.m_wvalid_o, busy); end
    comps++; if (bus.m_wdata_o !== 32'h0 || bus.m_awaddr_o !== 32'h0) begin fails++; $display("FAIL rstmid_clear got data=%0h addr=%0h exp=0/0", bus.m_wdata_o, bus.m_awaddr_o); end
    cfg_enable = 1'b0;
    areset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.m_awready_i = 1'b0; bus.m_wready_i = 1'b0; bus.m_bvalid_i = 1'b0; bus.m_bresp_i = 2'b00;
    test_reset();
    test_basic();
    test_enable_drop();
    test_stall();
    test_len_zero();
    test_wrap();
    test_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end
endmodule
